// File: rtl/serial_add_seq_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
//   Shared types and limits for the bit-serial adder (serial_add_seq).
//   - sa_state_e : control FSM states (IDLE -> RUN -> DONE -> IDLE)
//   - MAX_WIDTH  : widest operand the block is meant to be built for
// ---------------------------------------------------------------------------
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sa_state_e;

  localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/serial_add_seq_if.sv
// ---------------------------------------------------------------------------
// serial_add_seq_if
//   Handshake bundle for serial_add_seq.
//   Operand side : in_valid, in_ready, a, b, cin
//   Result side  : out_valid, out_ready, sum, cout (+ ovf with SERIAL_ADD_OVF_EN)
//   Status       : busy
//   modport slave  : the adder block
//   modport master : whoever issues operands and consumes results
//   Optional feature macro: SERIAL_ADD_OVF_EN (adds the ovf signal).
// ---------------------------------------------------------------------------
interface serial_add_seq_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
`ifdef SERIAL_ADD_OVF_EN
    , ovf
`endif
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
`ifdef SERIAL_ADD_OVF_EN
    , ovf
`endif
  );

endinterface

// File: rtl/serial_add_seq_fa_bit.sv
// ---------------------------------------------------------------------------
// fa_bit
//   Combinational one-bit full adder.
//   a, b, ci : addend bits and carry in
//   s        : sum bit  (a ^ b ^ ci)
//   co       : carry out (majority of a, b, ci)
// ---------------------------------------------------------------------------
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_seq.sv
// ---------------------------------------------------------------------------
// serial_add_seq
//   Bit-serial adder front-end. Captures two WIDTH-bit operands plus carry-in
//   on an accepted handshake, then ripples them LSB-first through a single
//   fa_bit cell, one bit per clock, with the carry held in a register.
//   The WIDTH-bit sum and carry-out are presented with a valid/ready handshake.
//
//   Ports:
//     clk   : clock, all state changes on its rising edge
//     rst_n : asynchronous, active-low reset
//     bus   : serial_add_seq_if.slave
//               in_valid/in_ready/a/b/cin     operand handshake
//               out_valid/out_ready/sum/cout  result handshake
//               busy                          high while RUN or DONE
//               ovf                           signed overflow (SERIAL_ADD_OVF_EN)
//
//   Optional feature macro: SERIAL_ADD_OVF_EN
//     defined   -> ovf = carry into MSB ^ carry out of MSB, held with sum
//     undefined -> no overflow logic at all
//
//   Timing: accept at edge E0, bits processed at E1..E_WIDTH, out_valid high
//   after E_WIDTH, result released at the edge where out_ready is seen, and
//   in_ready returns one edge later (one op every WIDTH+2 cycles).
// ---------------------------------------------------------------------------
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  serial_add_seq_if.slave bus
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  sa_state_e        state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             out_valid_reg;
  logic             in_ready_reg;
  logic             busy_reg;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_reg;
`endif

  logic fa_s;
  logic fa_co;

  // The single arithmetic cell: always looks at bit 0 of the operand shifters.
  fa_bit u_fa_bit (
    .a  (a_sh_reg[0]),
    .b  (b_sh_reg[0]),
    .ci (carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      cout_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      busy_reg      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh_reg     <= bus.a;
            b_sh_reg     <= bus.b;
            carry_reg    <= bus.cin;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= RUN;
          end
        end

        RUN: begin
          a_sh_reg  <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg  <= {1'b0, b_sh_reg[WIDTH-1:1]};
          // New sum bit enters at the top; after WIDTH shifts bit 0 lands at bit 0.
          sum_reg   <= {fa_s, sum_reg[WIDTH-1:1]};
          carry_reg <= fa_co;
          cnt_reg   <= cnt_reg + CNT_ONE;
          if (cnt_reg == LAST_BIT) begin
            cout_reg      <= fa_co;
            out_valid_reg <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
            // On the MSB step carry_reg is exactly the carry into the MSB.
            ovf_reg       <= carry_reg ^ fa_co;
`endif
            state_reg     <= DONE;
          end
        end

        DONE: begin
          // No same-cycle accept: in_ready only rises after this release edge.
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.busy      = busy_reg;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// ---------------------------------------------------------------------------
// tb_serial_add_seq
//   Scoreboard bench for serial_add_seq (WIDTH=8). The driver pushes the
//   expected result of each accepted op into a queue; an independent monitor
//   pops and compares whenever a result is handed over (out_valid && out_ready).
//   Expected values come from plain integer addition.
//   Honours SERIAL_ADD_OVF_EN for the ovf checks.
// ---------------------------------------------------------------------------
module tb_serial_add_seq;

  localparam int WIDTH = 8;

  typedef logic [WIDTH+1:0] exp_t;   // {ovf, cout, sum}

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  serial_add_seq_if #(.WIDTH(WIDTH)) sif ();

  serial_add_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;
  exp_t exp_q[$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: plain (WIDTH+1)-bit addition; signed overflow when both
  // operands share a sign and the sum's sign differs.
  function automatic exp_t model(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic c);
    logic [WIDTH:0] full;
    logic           ov;
    full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    ov   = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return {ov, full};
  endfunction

  // Monitor: one comparison set per handed-over result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && sif.out_valid && sif.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {63'd0, sif.out_valid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          txn++;
          $display("txn %0d: sum=0x%02h cout=%0b (model sum=0x%02h cout=%0b)",
                   txn, sif.sum, sif.cout, e[WIDTH-1:0], e[WIDTH]);
          chk("sum", 64'(sif.sum), 64'(e[WIDTH-1:0]));
          chk("cout", 64'(sif.cout), 64'(e[WIDTH]));
`ifdef SERIAL_ADD_OVF_EN
          chk("ovf", 64'(sif.ovf), 64'(e[WIDTH+1]));
`endif
        end
      end
    end
  end

  // Issue one op; returns 2 time units after the accepting edge E0.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic c, input bit track);
    int n;
    n = 0;
    @(negedge clk);
    while (!sif.in_ready) begin
      if (n >= 64) begin
        chk("in_ready_timeout", 64'(sif.in_ready), 64'd1);
        return;
      end
      @(negedge clk);
      n++;
    end
    sif.a        = a;
    sif.b        = b;
    sif.cin      = c;
    sif.in_valid = 1'b1;
    @(posedge clk);
    #2;
    sif.in_valid = 1'b0;
    // Scramble the inputs: the op in flight must not see them.
    sif.a   = WIDTH'($urandom);
    sif.b   = WIDTH'($urandom);
    sif.cin = 1'($urandom);
    if (track) exp_q.push_back(model(a, b, c));
  endtask

  // Count edges after E0 until out_valid; 'already' edges have passed.
  task automatic wait_latency(input int already);
    int k;
    for (k = already; k <= 3 * WIDTH; k++) begin
      @(negedge clk);
      if (sif.out_valid) break;
    end
    chk("latency", 64'(k), 64'(WIDTH));
  endtask

  initial begin
    exp_t e;
    int   d;
    logic [WIDTH-1:0] ra, rb;
    logic rc;

    sif.in_valid  = 1'b0;
    sif.a         = '0;
    sif.b         = '0;
    sif.cin       = 1'b0;
    sif.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(sif.out_valid), 64'd0);
    chk("rst_sum", 64'(sif.sum), 64'd0);
    chk("rst_cout", 64'(sif.cout), 64'd0);
    chk("rst_busy", 64'(sif.busy), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", 64'(sif.ovf), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(sif.in_ready), 64'd1);

    // Directed corner operands
    send(8'h00, 8'h00, 1'b0, 1'b1); wait_latency(0);
    send(8'hFF, 8'h01, 1'b0, 1'b1); wait_latency(0);
    send(8'h7F, 8'h01, 1'b0, 1'b1); wait_latency(0);
    send(8'h35, 8'h4A, 1'b1, 1'b1); wait_latency(0);
    send(8'hFF, 8'hFF, 1'b1, 1'b1); wait_latency(0);
    send(8'h80, 8'h80, 1'b0, 1'b1); wait_latency(0);

    // Back-pressure: hold out_ready low 5 clocks in DONE
    e = model(8'hA5, 8'h3C, 1'b0);
    send(8'hA5, 8'h3C, 1'b0, 1'b1);
    #1 sif.out_ready = 1'b0;
    wait_latency(0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_valid", 64'(sif.out_valid), 64'd1);
      chk("hold_sum", 64'(sif.sum), 64'(e[WIDTH-1:0]));
      chk("hold_cout", 64'(sif.cout), 64'(e[WIDTH]));
      chk("hold_in_ready", 64'(sif.in_ready), 64'd0);
      sif.in_valid = 1'b1;
      sif.a        = WIDTH'($urandom);
      sif.b        = WIDTH'($urandom);
      @(posedge clk);
      #2 sif.in_valid = 1'b0;
    end
    sif.out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready_low", 64'(sif.in_ready), 64'd0);
    @(negedge clk);
    chk("release_in_ready", 64'(sif.in_ready), 64'd1);
    chk("release_valid", 64'(sif.out_valid), 64'd0);
    chk("release_busy", 64'(sif.busy), 64'd0);
    chk("release_sum_kept", 64'(sif.sum), 64'(e[WIDTH-1:0]));

    // Operand change and ignored in_valid during RUN
    send(8'h5A, 8'h96, 1'b1, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    sif.a        = 8'hFF;
    sif.b        = 8'hFF;
    sif.cin      = 1'b1;
    sif.in_valid = 1'b1;
    @(posedge clk);
    #2 sif.in_valid = 1'b0;
    wait_latency(3);

    // Reset during RUN aborts the op
    send(8'h11, 8'h22, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(sif.out_valid), 64'd0);
    chk("abort_busy", 64'(sif.busy), 64'd0);
    chk("abort_sum", 64'(sif.sum), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", 64'(sif.in_ready), 64'd1);
    send(8'h01, 8'h02, 1'b0, 1'b1); wait_latency(0);

    // Randomised ops with random back-pressure
    for (int i = 0; i < 30; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      d  = $urandom_range(0, 3);
      send(ra, rb, rc, 1'b1);
      if (d > 0) #1 sif.out_ready = 1'b0;
      wait_latency(0);
      if (d > 0) begin
        repeat (d) @(posedge clk);
        #2 sif.out_ready = 1'b1;
      end
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
